// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Purpose  : Shared types, default widths and the exact fixed-point
//            multiply-and-shift reference for the shared multiplier arbiter.
// Contents : DEF_IN_W / DEF_OUT_W / DEF_SHIFT_WIDTH  default widths
//            operand_t, result_t, product_t          signed data types
//            fx_mul_shift(a, b)                      exact (a*b) >>> shift
// Revision : 1.0  initial release
// ============================================================================
package mult_arb_pkg;

  localparam int DEF_IN_W        = 16;
  localparam int DEF_OUT_W       = 32;
  localparam int DEF_SHIFT_WIDTH = 8;
  localparam int DEF_PROD_W      = 2 * DEF_IN_W;

  typedef logic signed [DEF_IN_W-1:0]   operand_t;
  typedef logic signed [DEF_OUT_W-1:0]  result_t;
  typedef logic signed [DEF_PROD_W-1:0] product_t;

  // Full-precision signed product, arithmetic shift (floors toward -inf),
  // then keep the low DEF_OUT_W bits.
  function automatic result_t fx_mul_shift(input operand_t a, input operand_t b);
    product_t prod;
    prod = product_t'(a) * product_t'(b);
    return result_t'(prod >>> DEF_SHIFT_WIDTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_core.sv
`default_nettype none
// ============================================================================
// Module   : mult_core
// Purpose  : Combinational signed fixed-point multiplier with arithmetic
//            right shift. APPROX=0 gives the exact result; APPROX=1 uses a
//            truncated-operand sign-magnitude approximation.
// Ports    : a_i  in  IN_W   signed operand A
//            b_i  in  IN_W   signed operand B
//            p_o  out OUT_W  (A*B) >>> SHIFT_WIDTH, low OUT_W bits
// Revision : 1.0  initial release
// ============================================================================
module mult_core
  import mult_arb_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int APPROX      = 1
) (
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] p_o
);

  localparam int c_prod_w = 2 * IN_W;
  // Working width wide enough for both the full product and the result.
  localparam int c_ext_w  = (c_prod_w > OUT_W) ? c_prod_w : OUT_W;
  // Number of operand LSBs discarded by the approximate datapath.
  localparam int c_drop   = 4;

  if (APPROX == 0) begin : g_exact
    if (IN_W == DEF_IN_W && OUT_W == DEF_OUT_W && SHIFT_WIDTH == DEF_SHIFT_WIDTH) begin : g_pkg
      assign p_o = fx_mul_shift(a_i, b_i);
    end else begin : g_generic
      logic signed [c_ext_w-1:0] w_prod;
      // Size casts keep signedness, so operands are sign-extended first.
      assign w_prod = c_ext_w'(a_i) * c_ext_w'(b_i);
      assign p_o    = OUT_W'(w_prod >>> SHIFT_WIDTH);
    end
  end else begin : g_approx
    localparam logic [IN_W-1:0] c_keep = ~IN_W'((1 << c_drop) - 1);

    logic                      w_neg;
    logic [IN_W-1:0]           w_mag_a;
    logic [IN_W-1:0]           w_mag_b;
    logic [c_prod_w-1:0]       w_mag_p;
    logic signed [c_ext_w-1:0] w_sprod;

    // Magnitude of the most negative value still fits as unsigned IN_W bits.
    assign w_neg   = a_i[IN_W-1] ^ b_i[IN_W-1];
    assign w_mag_a = (a_i[IN_W-1] ? -a_i : a_i) & c_keep;
    assign w_mag_b = (b_i[IN_W-1] ? -b_i : b_i) & c_keep;
    assign w_mag_p = c_prod_w'(w_mag_a) * c_prod_w'(w_mag_b);
    assign w_sprod = w_neg ? -c_ext_w'($signed(w_mag_p)) : c_ext_w'($signed(w_mag_p));
    assign p_o     = OUT_W'(w_sprod >>> SHIFT_WIDTH);
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Purpose  : Round-robin arbiter time-sharing one signed fixed-point
//            multiplier among NREQ requesters. Two-stage pipeline:
//            S1 registers the granted operands, S2 registers the shifted
//            product and drives the backpressured output port.
// Ports    : clk        in  1          clock
//            rst        in  1          synchronous active-high reset
//            req_valid  in  NREQ       per-requester operand valid
//            req_a      in  NREQ*IN_W  packed signed operand A
//            req_b      in  NREQ*IN_W  packed signed operand B
//            req_ready  out NREQ       one-hot (or zero) accept
//            out_valid  out 1          result valid
//            out_ready  in  1          downstream accept
//            out_data   out OUT_W      shifted signed product
//            out_id     out ID_W       originating requester index
//            busy       out 1          either stage holds data
//            xfer_cnt   out 32         accepted-request count (wraps)
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int APPROX      = 1,
  parameter int ID_W        = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IN_W-1:0]   req_a,
  input  logic [NREQ*IN_W-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  output logic                   busy,
  output logic [31:0]            xfer_cnt
);

  // --------------------------------------------------------------------------
  // Pipeline and arbitration state
  // --------------------------------------------------------------------------
  logic                    v1_q,    v1_d;
  logic signed [IN_W-1:0]  a1_q,    a1_d;
  logic signed [IN_W-1:0]  b1_q,    b1_d;
  logic [ID_W-1:0]         id1_q,   id1_d;
  logic                    v2_q,    v2_d;
  logic [OUT_W-1:0]        data2_q, data2_d;
  logic [ID_W-1:0]         id2_q,   id2_d;
  logic [ID_W-1:0]         ptr_q,   ptr_d;
  logic [31:0]             cnt_q,   cnt_d;

  logic                    w_adv1;
  logic                    w_adv2;
  logic                    w_found;
  logic                    w_accept;
  logic [NREQ-1:0]         w_grant;
  logic [ID_W-1:0]         w_gnt_idx;
  logic [ID_W-1:0]         w_scan;
  logic signed [IN_W-1:0]  w_sel_a;
  logic signed [IN_W-1:0]  w_sel_b;
  logic signed [OUT_W-1:0] w_prod;

  // S2 frees up when empty or being drained; S1 frees up when empty or
  // when it can move into S2.
  assign w_adv2 = ~v2_q | out_ready;
  assign w_adv1 = ~v1_q | w_adv2;

  // --------------------------------------------------------------------------
  // Round-robin grant: first valid requester at or after ptr, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!w_found && req_valid[w_scan]) begin
        w_found         = 1'b1;
        w_grant[w_scan] = 1'b1;
        w_gnt_idx       = w_scan;
      end
    end
  end

  // Reset gates ready so nothing is accepted in the reset cycle.
  assign w_accept  = w_found & w_adv1 & ~rst;
  assign req_ready = w_grant & {NREQ{w_adv1 & ~rst}};

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*IN_W +: IN_W];
        w_sel_b = req_b[i*IN_W +: IN_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shared multiplier between S1 and S2
  // --------------------------------------------------------------------------
  mult_core #(
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .APPROX      (APPROX)
  ) u_core (
    .a_i (a1_q),
    .b_i (b1_q),
    .p_o (w_prod)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    id1_d   = id1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    id2_d   = id2_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (w_adv2) begin
      // An empty S1 moving forward leaves a bubble in S2.
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = w_prod;
        id2_d   = id1_q;
      end
    end

    if (w_adv1) begin
      v1_d = w_accept;
      if (w_accept) begin
        a1_d  = w_sel_a;
        b1_d  = w_sel_b;
        id1_d = w_gnt_idx;
        ptr_d = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      id1_q   <= '0;
      v2_q    <= 1'b0;
      data2_q <= '0;
      id2_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      id1_q   <= id1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
      id2_q   <= id2_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_id    = id2_q;
  assign busy      = v1_q | v2_q;
  assign xfer_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Purpose  : Self-checking bench for mult_share_arb (exact multiplier).
//            A transaction-level model (queue of in-flight results, RR
//            pointer, acceptance counter) predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int IN_W = 16;
  localparam int OUT_W = 32;
  localparam int SW = 8;
  localparam int ID_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*IN_W-1:0]  req_a;
  logic [NREQ*IN_W-1:0]  req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [ID_W-1:0]       out_id;
  logic                  busy;
  logic [31:0]           xfer_cnt;

  always #5 clk = ~clk;

  mult_share_arb #(
    .NREQ        (NREQ),
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .SHIFT_WIDTH (SW),
    .APPROX      (0),
    .ID_W        (ID_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          t;     // edge index at which the request was accepted
  } item_t;

  item_t           q[$];
  int              m_ptr;
  int              m_cnt;
  int              cyc;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [NREQ-1:0] rdy_seen;
  int              acc_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Plain-arithmetic reference: exact signed product, floor shift, truncate.
  function automatic logic [31:0] ref_fx(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 32'(p >>> SW);
  endfunction

  function automatic logic [NREQ*IN_W-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  // One clock cycle: drive inputs, compare all outputs with the model,
  // then advance the model by the same edge.
  task automatic step(input logic r, input logic [NREQ-1:0] v,
                      input logic [NREQ*IN_W-1:0] a, input logic [NREQ*IN_W-1:0] b,
                      input logic ordy);
    logic [NREQ-1:0] exp_rdy;
    logic            exp_ov;
    int              g;
    item_t           it;
    @(negedge clk);
    rst = r; req_valid = v; req_a = a; req_b = b; out_ready = ordy;
    #1;
    exp_rdy = '0;
    g = -1;
    // Room exists unless both stages are full and the output is stalled.
    if (!r && (q.size() < 2 || ordy)) begin
      for (int d = 0; d < NREQ; d++)
        if (g < 0 && v[(m_ptr + d) % NREQ]) g = (m_ptr + d) % NREQ;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    // A result is visible once it has spent one edge in the first stage.
    exp_ov = (q.size() >= 2) || (q.size() == 1 && q[0].t < cyc - 1);
    rdy_seen = req_ready;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("out_valid", 32'(out_valid), 32'(exp_ov));
    check_val("busy", 32'(busy), 32'(q.size() != 0));
    check_val("xfer_cnt", xfer_cnt, 32'(m_cnt));
    if (exp_ov) begin
      check_val("out_data", out_data, q[0].data);
      check_val("out_id", 32'(out_id), 32'(q[0].id));
    end
    if (r) begin
      q.delete();
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (g >= 0) begin
        it.id   = g;
        it.data = ref_fx(a[g*IN_W +: IN_W], b[g*IN_W +: IN_W]);
        it.t    = cyc;
        q.push_back(it);
        m_ptr = (g + 1) % NREQ;
        m_cnt++;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic [NREQ*IN_W-1:0] ra;
    logic [NREQ*IN_W-1:0] rb;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b0;
    cyc = 0; m_ptr = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    cyc = 2;

    // Reset state, with every requester asking during reset.
    step(1'b1, 4'b1111, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
    #1;
    check_val("rst_data", out_data, 32'd0);
    check_val("rst_id", 32'(out_id), 32'd0);

    // Single request: 100 * -440 >>> 8 = -172, two edges later.
    step(1'b0, 4'b0001, pack4(100, 0, 0, 0), pack4(-440, 0, 0, 0), 1'b1);
    step(1'b0, 4'b0000, '0, '0, 1'b1);
    #1;
    check_val("single_valid", 32'(out_valid), 32'd1);
    check_val("single_data", out_data, -172);
    check_val("single_id", 32'(out_id), 32'd0);
    check_val("single_cnt", xfer_cnt, 32'd1);

    // Extremes.
    step(1'b0, 4'b0010, pack4(0, -32768, 0, 0), pack4(0, -32768, 0, 0), 1'b1);
    step(1'b0, 4'b0010, pack4(0, -1, 0, 0), pack4(0, 1, 0, 0), 1'b1);
    #1;
    check_val("ext_max", out_data, 32'd4194304);
    step(1'b0, 4'b0000, '0, '0, 1'b1);
    #1;
    check_val("ext_floor", out_data, -1);

    // All four requesting: strict 0,1,2,3 rotation at full rate.
    step(1'b1, '0, '0, '0, 1'b1);
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 4'b1111, pack4(1, 2, 3, 4), pack4(256, 256, 256, 256), 1'b1);
      check_val("rr_order", 32'(rdy_seen), 32'(1 << (j % 4)));
    end
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);

    // Backpressure after the first result: only S1 refills.
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b0, 4'b0001, pack4(7, 0, 0, 0), pack4(512, 0, 0, 0), 1'b1);
    step(1'b0, 4'b0000, '0, '0, 1'b1);
    acc_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 4'b1111, pack4(10, 20, 30, 40), pack4(-300, 300, -300, 300), 1'b0);
      acc_cnt += $countones(rdy_seen);
    end
    check_val("stall_accepts", 32'(acc_cnt), 32'd1);
    for (int j = 0; j < 4; j++) step(1'b0, 4'b0000, '0, '0, 1'b1);

    // Pointer: after serving 1, requesters 3 and 0 go 3 first, then 0.
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b0, 4'b0010, pack4(0, 5, 0, 0), pack4(0, 6, 0, 0), 1'b1);
    step(1'b0, 4'b1001, pack4(11, 0, 0, 13), pack4(-999, 0, 0, 777), 1'b1);
    check_val("ptr_first", 32'(rdy_seen), 32'b1000);
    step(1'b0, 4'b1001, pack4(11, 0, 0, 13), pack4(-999, 0, 0, 777), 1'b1);
    check_val("ptr_second", 32'(rdy_seen), 32'b0001);
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);

    // Reset with both stages full: in-flight results vanish.
    step(1'b0, 4'b0001, pack4(300, 0, 0, 0), pack4(300, 0, 0, 0), 1'b0);
    step(1'b0, 4'b0010, pack4(0, 400, 0, 0), pack4(0, 400, 0, 0), 1'b0);
    step(1'b0, 4'b0100, pack4(0, 0, 500, 0), pack4(0, 0, 500, 0), 1'b0);
    step(1'b1, 4'b1111, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_cnt", xfer_cnt, 32'd0);
    check_val("mid_rst_data", out_data, 32'd0);
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b0, 4'b1111, pack4(2, 3, 4, 5), pack4(6, 7, 8, 9), 1'b1);
    check_val("mid_rst_ptr", 32'(rdy_seen), 32'b0001);

    // Randomized traffic with occasional resets and backpressure.
    for (int j = 0; j < 600; j++) begin
      for (int k = 0; k < NREQ; k++) begin
        case ($urandom_range(0, 7))
          0:       begin ra[k*IN_W +: IN_W] = 16'h8000; rb[k*IN_W +: IN_W] = 16'(  $urandom); end
          1:       begin ra[k*IN_W +: IN_W] = 16'hFFFF; rb[k*IN_W +: IN_W] = 16'h7FFF; end
          default: begin ra[k*IN_W +: IN_W] = 16'($urandom); rb[k*IN_W +: IN_W] = 16'($urandom); end
        endcase
      end
      step(($urandom_range(0, 79) == 0), 4'($urandom), ra, rb, ($urandom_range(0, 3) != 0));
    end
    for (int j = 0; j < 4; j++) step(1'b0, '0, '0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
